// File: rtl/mips_multicycle_control.sv
// rtl/mips_multicycle_control.sv - multi-cycle MIPS control FSM (optional INSTR_COUNT_EN retired-instruction counter)
module mips_multicycle_control #(
  parameter int ALUOP_WIDTH   = 3,
  parameter int MULDIV_CYCLES = 32
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [5:0]             opcode,
  input  logic [5:0]             funct,
  input  logic                   pc_is_zero,
  input  logic                   mem_waitrequest,
  output logic                   active,
  output logic [2:0]             state,
  output logic                   pc_write,
  output logic                   pc_write_cond,
  output logic [1:0]             pc_source,
  output logic                   iord,
  output logic                   mem_read,
  output logic                   mem_write,
  output logic                   ir_write,
  output logic [1:0]             reg_dst,
  output logic                   mem_to_reg,
  output logic                   reg_write,
  output logic                   alu_src_a,
  output logic [1:0]             alu_src_b,
  output logic [ALUOP_WIDTH-1:0] alu_op,
  output logic                   hi_lo_write
`ifdef INSTR_COUNT_EN
  ,
  output logic [31:0]            instr_count
`endif
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_MULDIV = 3'd5,
    S_HALT   = 3'd6
  } state_t;

  localparam int CW = (MULDIV_CYCLES > 1) ? $clog2(MULDIV_CYCLES) : 1;

  localparam logic [2:0] ALU_ADD = 3'd0, ALU_SUB = 3'd1, ALU_FUN = 3'd2, ALU_AND = 3'd3,
                         ALU_OR  = 3'd4, ALU_XOR = 3'd5, ALU_SLT = 3'd6, ALU_LUI = 3'd7;

  state_t        state_q, state_d;
  logic [CW-1:0] count_q, count_d;

  logic       is_rtype, is_jr, is_muldiv, is_ralu, is_load, is_store, is_ialu;
  logic [2:0] ialu_op, aop;

  // Instruction class decode from the IR fields
  always_comb begin
    is_rtype  = (opcode == 6'h00);
    is_jr     = is_rtype && (funct == 6'h08);
    is_muldiv = is_rtype && (funct[5:2] == 4'b0110);
    is_ralu   = 1'b0;
    if (is_rtype) begin
      case (funct)
        6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07, 6'h10, 6'h12,
        6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27,
        6'h2A, 6'h2B: is_ralu = 1'b1;
        default:      is_ralu = 1'b0;
      endcase
    end
    is_load  = (opcode == 6'h23);
    is_store = (opcode == 6'h2B) || (opcode == 6'h28) || (opcode == 6'h29);
    is_ialu  = 1'b1;
    ialu_op  = ALU_ADD;
    case (opcode)
      6'h09:   ialu_op = ALU_ADD;
      6'h0A:   ialu_op = ALU_SLT;
      6'h0C:   ialu_op = ALU_AND;
      6'h0D:   ialu_op = ALU_OR;
      6'h0E:   ialu_op = ALU_XOR;
      6'h0F:   ialu_op = ALU_LUI;
      default: is_ialu = 1'b0;
    endcase
  end

  // Next-state and Moore outputs; reset forces every strobe and select low
  always_comb begin
    state_d       = state_q;
    count_d       = count_q;
    active        = 1'b1;
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    pc_source     = 2'd0;
    iord          = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    ir_write      = 1'b0;
    reg_dst       = 2'd0;
    mem_to_reg    = 1'b0;
    reg_write     = 1'b0;
    alu_src_a     = 1'b0;
    alu_src_b     = 2'd0;
    aop           = ALU_ADD;
    hi_lo_write   = 1'b0;
    if (!reset) begin
      case (state_q)
        S_FETCH: begin
          if (pc_is_zero) begin
            state_d = S_HALT;
          end else begin
            mem_read  = 1'b1;
            alu_src_b = 2'd1;
            if (!mem_waitrequest) begin
              ir_write = 1'b1;
              pc_write = 1'b1;
              state_d  = S_DECODE;
            end
          end
        end
        S_DECODE: begin
          alu_src_b = 2'd3;
          state_d   = S_EXEC;
        end
        S_EXEC: begin
          state_d = S_FETCH;
          if (is_jr) begin
            pc_write  = 1'b1;
            pc_source = 2'd3;
          end else if (is_muldiv) begin
            count_d = CW'(MULDIV_CYCLES - 1);
            state_d = S_MULDIV;
          end else if (is_ralu) begin
            alu_src_a = 1'b1;
            aop       = ALU_FUN;
            state_d   = S_WB;
          end else if (is_load || is_store) begin
            alu_src_a = 1'b1;
            alu_src_b = 2'd2;
            state_d   = S_MEM;
          end else if (opcode == 6'h04 || opcode == 6'h05) begin
            alu_src_a     = 1'b1;
            aop           = ALU_SUB;
            pc_write_cond = 1'b1;
            pc_source     = 2'd1;
          end else if (opcode == 6'h02 || opcode == 6'h03) begin
            pc_write  = 1'b1;
            pc_source = 2'd2;
            if (opcode == 6'h03) state_d = S_WB;
          end else if (is_ialu) begin
            alu_src_a = 1'b1;
            alu_src_b = 2'd2;
            aop       = ialu_op;
            state_d   = S_WB;
          end
        end
        S_MEM: begin
          iord      = 1'b1;
          mem_read  = is_load;
          mem_write = !is_load;
          if (!mem_waitrequest) state_d = is_load ? S_WB : S_FETCH;
        end
        S_WB: begin
          reg_write  = 1'b1;
          mem_to_reg = is_load;
          reg_dst    = is_rtype ? 2'd1 : (opcode == 6'h03) ? 2'd2 : 2'd0;
          state_d    = S_FETCH;
        end
        S_MULDIV: begin
          if (count_q == '0) begin
            hi_lo_write = 1'b1;
            state_d     = S_FETCH;
          end else begin
            count_d = count_q - CW'(1);
          end
        end
        S_HALT: active = 1'b0;
        default: state_d = S_FETCH;
      endcase
    end
  end

  assign alu_op = ALUOP_WIDTH'(aop);
  assign state  = state_q;

  // State register and mult/div countdown
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_FETCH;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
    end
  end

`ifdef INSTR_COUNT_EN
  logic [31:0] instr_count_q, instr_count_d;

  // One count per retirement: any return to FETCH from a post-decode state
  always_comb begin
    instr_count_d = instr_count_q;
    if (!reset && state_d == S_FETCH &&
        (state_q == S_EXEC || state_q == S_MEM || state_q == S_WB || state_q == S_MULDIV))
      instr_count_d = instr_count_q + 32'd1;
  end

  // Retired-instruction counter register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) instr_count_q <= 32'd0;
    else       instr_count_q <= instr_count_d;
  end

  assign instr_count = instr_count_q;
`endif

endmodule

// File: tb/tb_mips_multicycle_control.sv
// tb/tb_mips_multicycle_control.sv - scoreboard bench for mips_multicycle_control
module tb_mips_multicycle_control;

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] opcode, funct;
  logic       pc_is_zero, mem_waitrequest;
  logic       active, pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write;
  logic       mem_to_reg, reg_write, alu_src_a, hi_lo_write;
  logic [2:0] state, alu_op;
  logic [1:0] pc_source, reg_dst, alu_src_b;
`ifdef INSTR_COUNT_EN
  logic [31:0] instr_count;
`endif

  mips_multicycle_control #(.ALUOP_WIDTH(3), .MULDIV_CYCLES(4)) dut (
    .clk(clk), .reset(reset), .opcode(opcode), .funct(funct),
    .pc_is_zero(pc_is_zero), .mem_waitrequest(mem_waitrequest),
    .active(active), .state(state), .pc_write(pc_write), .pc_write_cond(pc_write_cond),
    .pc_source(pc_source), .iord(iord), .mem_read(mem_read), .mem_write(mem_write),
    .ir_write(ir_write), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .reg_write(reg_write),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op), .hi_lo_write(hi_lo_write)
`ifdef INSTR_COUNT_EN
    , .instr_count(instr_count)
`endif
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  logic [22:0] exp_q[$];
  string       name_q[$];
  longint      cnt_q[$];

  int cur_op = 0;
  int cur_fn = 0;

  // Expected-vector packer: field order matches the monitor's concatenation
  function automatic logic [22:0] mk(input int st, act, pw, pwc, ps, io, mr, mw, irw,
                                     rd, m2r, rw, asa, asb, aop, hl);
    return {1'(act), 3'(st), 1'(pw), 1'(pwc), 2'(ps), 1'(io), 1'(mr), 1'(mw), 1'(irw),
            2'(rd), 1'(m2r), 1'(rw), 1'(asa), 2'(asb), 3'(aop), 1'(hl)};
  endfunction

  // Apply one cycle of inputs just after the edge and queue the expected outputs
  task automatic s(input logic [22:0] e, input string nm, input int wr = 0, input int pz = 0,
                   input int rst_i = 0, input longint c = -1);
    @(posedge clk);
    #1;
    reset           = 1'(rst_i);
    opcode          = 6'(cur_op);
    funct           = 6'(cur_fn);
    pc_is_zero      = 1'(pz);
    mem_waitrequest = 1'(wr);
    exp_q.push_back(e);
    name_q.push_back(nm);
    cnt_q.push_back(c);
  endtask

  // Monitor: compare DUT outputs against the scoreboard at every falling edge
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      logic [22:0] act_v, e;
      string       nm;
      longint      c;
      e  = exp_q.pop_front();
      nm = name_q.pop_front();
      c  = cnt_q.pop_front();
      act_v = {active, state, pc_write, pc_write_cond, pc_source, iord, mem_read, mem_write,
               ir_write, reg_dst, mem_to_reg, reg_write, alu_src_a, alu_src_b, alu_op, hi_lo_write};
      vectors++;
      if (act_v !== e) begin
        miscompares++;
        $display("FAIL %s: got %06h expected %06h", nm, act_v, e);
      end
`ifdef INSTR_COUNT_EN
      if (c >= 0) begin
        vectors++;
        if (instr_count !== 32'(c)) begin
          miscompares++;
          $display("FAIL %s_count: got %0d expected %0d", nm, instr_count, c);
        end
      end
`endif
    end
  end

  logic [22:0] R, FG, FW, DC, H;

  initial begin
    reset = 1'b1; opcode = '0; funct = '0; pc_is_zero = 1'b0; mem_waitrequest = 1'b0;
    R  = mk(0,1,0,0,0,0,0,0,0,0,0,0,0,0,0,0);
    FG = mk(0,1,1,0,0,0,1,0,1,0,0,0,0,1,0,0);
    FW = mk(0,1,0,0,0,0,1,0,0,0,0,0,0,1,0,0);
    DC = mk(1,1,0,0,0,0,0,0,0,0,0,0,0,3,0,0);
    H  = mk(6,0,0,0,0,0,0,0,0,0,0,0,0,0,0,0);

    s(R, "reset", 0, 0, 1, 0);

    // addu: FETCH, DECODE, EXEC, WB
    cur_op = 'h00; cur_fn = 'h21;
    s(FG, "addu_fetch"); s(DC, "addu_decode");
    s(mk(2,1,0,0,0,0,0,0,0,0,0,0,1,0,2,0), "addu_exec");
    s(mk(4,1,0,0,0,0,0,0,0,1,0,1,0,0,0,0), "addu_wb");

    // lw with one fetch stall and three MEM stall cycles
    cur_op = 'h23; cur_fn = 0;
    s(FW, "lw_fetch_wait", 1); s(FG, "lw_fetch"); s(DC, "lw_decode");
    s(mk(2,1,0,0,0,0,0,0,0,0,0,0,1,2,0,0), "lw_exec");
    for (int i = 0; i < 4; i++)
      s(mk(3,1,0,0,0,1,1,0,0,0,0,0,0,0,0,0), "lw_mem", (i < 3) ? 1 : 0);
    s(mk(4,1,0,0,0,0,0,0,0,0,1,1,0,0,0,0), "lw_wb");

    // sw with one MEM stall cycle
    cur_op = 'h2B;
    s(FG, "sw_fetch"); s(DC, "sw_decode");
    s(mk(2,1,0,0,0,0,0,0,0,0,0,0,1,2,0,0), "sw_exec");
    s(mk(3,1,0,0,0,1,0,1,0,0,0,0,0,0,0,0), "sw_mem_wait", 1);
    s(mk(3,1,0,0,0,1,0,1,0,0,0,0,0,0,0,0), "sw_mem");

    // mult: four MULDIV cycles, hi_lo_write only in the last
    cur_op = 'h00; cur_fn = 'h18;
    s(FG, "mult_fetch"); s(DC, "mult_decode");
    s(mk(2,1,0,0,0,0,0,0,0,0,0,0,0,0,0,0), "mult_exec");
    for (int i = 0; i < 4; i++)
      s(mk(5,1,0,0,0,0,0,0,0,0,0,0,0,0,0,(i == 3) ? 1 : 0), "mult_muldiv");

    // beq then j
    cur_op = 'h04; cur_fn = 0;
    s(FG, "beq_fetch"); s(DC, "beq_decode");
    s(mk(2,1,0,1,1,0,0,0,0,0,0,0,1,0,1,0), "beq_exec");
    cur_op = 'h02;
    s(FG, "j_fetch"); s(DC, "j_decode");
    s(mk(2,1,1,0,2,0,0,0,0,0,0,0,0,0,0,0), "j_exec");

    // jal writes r31 in WB
    cur_op = 'h03;
    s(FG, "jal_fetch"); s(DC, "jal_decode");
    s(mk(2,1,1,0,2,0,0,0,0,0,0,0,0,0,0,0), "jal_exec");
    s(mk(4,1,0,0,0,0,0,0,0,2,0,1,0,0,0,0), "jal_wb");

    // ori
    cur_op = 'h0D;
    s(FG, "ori_fetch"); s(DC, "ori_decode");
    s(mk(2,1,0,0,0,0,0,0,0,0,0,0,1,2,4,0), "ori_exec");
    s(mk(4,1,0,0,0,0,0,0,0,0,0,1,0,0,0,0), "ori_wb");

    // jr
    cur_op = 'h00; cur_fn = 'h08;
    s(FG, "jr_fetch"); s(DC, "jr_decode");
    s(mk(2,1,1,0,3,0,0,0,0,0,0,0,0,0,0,0), "jr_exec");

    // unrecognised opcode retires as a NOP
    cur_op = 'h3F; cur_fn = 0;
    s(FG, "nop_fetch"); s(DC, "nop_decode");
    s(mk(2,1,0,0,0,0,0,0,0,0,0,0,0,0,0,0), "nop_exec");

    // mult aborted by reset once the counter reaches 2
    cur_op = 'h00; cur_fn = 'h19;
    s(FG, "mult2_fetch", 0, 0, 0, 10); s(DC, "mult2_decode");
    s(mk(2,1,0,0,0,0,0,0,0,0,0,0,0,0,0,0), "mult2_exec");
    s(mk(5,1,0,0,0,0,0,0,0,0,0,0,0,0,0,0), "mult2_muldiv");
    s(R, "mid_muldiv_reset", 0, 0, 1, 0);
    s(R, "reset_hold", 0, 0, 1, 0);

    // three addu after reset
    cur_op = 'h00; cur_fn = 'h21;
    for (int k = 0; k < 3; k++) begin
      s(FG, "addu_r_fetch", 0, 0, 0, k); s(DC, "addu_r_decode");
      s(mk(2,1,0,0,0,0,0,0,0,0,0,0,1,0,2,0), "addu_r_exec");
      s(mk(4,1,0,0,0,0,0,0,0,1,0,1,0,0,0,0), "addu_r_wb");
    end

    // pc_is_zero in FETCH: HALT is absorbing until reset
    s(R, "halt_fetch", 0, 1, 0, 3);
    for (int i = 0; i < 100; i++)
      s(H, "halt", i % 2, i % 3 == 0 ? 1 : 0, 0, (i == 99) ? 3 : -1);
    s(R, "halt_reset", 0, 0, 1, 0);
    s(FG, "post_halt_fetch");

    repeat (3) @(negedge clk);
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL drain: got %0d pending expected 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/mips_multicycle_control.md
Name: mips_multicycle_control

Overview:
- Multi-cycle, state-machine-driven successor to the single-cycle MIPS control decoder.
- Sequences fetch/decode/execute/memory/writeback for each instruction.
- Stalls on the memory wait handshake and runs a parametrised multi-cycle mult/div phase.
- Sits between the instruction register fields and the datapath muxes and write enables of the CPU core.

Parameters:
- ALUOP_WIDTH, 3, width of alu_op; must be >= 3.
- MULDIV_CYCLES, 32, cycles spent in MULDIV state for mult/multu/div/divu; must be >= 1.

Ports:
- clk  input  1  core clock, rising edge
- reset  input  1  asynchronous, active-high reset
- opcode  input  6  IR[31:26]
- funct  input  6  IR[5:0]
- pc_is_zero  input  1  PC currently equals 0x00000000 (halt address)
- mem_waitrequest  input  1  memory not ready; current access must be held
- active  output  1  high while CPU running; low in HALT
- state  output  3  current state encoding, for debug
- pc_write  output  1  unconditional PC load
- pc_write_cond  output  1  PC load if branch condition true
- pc_source  output  2  0 ALU result, 1 ALUOut (branch target), 2 jump target, 3 rs (jr)
- iord  output  1  0 PC address, 1 ALUOut address
- mem_read  output  1  memory read strobe
- mem_write  output  1  memory write strobe
- ir_write  output  1  IR load
- reg_dst  output  2  0 rt, 1 rd, 2 r31
- mem_to_reg  output  1  writeback selects MDR
- reg_write  output  1  register file write
- alu_src_a  output  1  0 PC, 1 rs
- alu_src_b  output  2  0 rt, 1 const 4, 2 sign-ext imm, 3 imm<<2
- alu_op  output  ALUOP_WIDTH  0 add, 1 sub, 2 funct-decode, 3 and, 4 or, 5 xor, 6 slt, 7 lui; upper bits zero
- hi_lo_write  output  1  HI/LO register load

Behaviour:
- State encoding: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, MULDIV=5, HALT=6.
- State register and muldiv counter are async-reset. On reset: state=FETCH, counter=0.
- While reset is high, all strobes are 0 (pc_write, pc_write_cond, ir_write, mem_read, mem_write, reg_write, hi_lo_write), all selects are 0, and active=1.
- Outputs are Moore-decoded from state, opcode and funct, except fetch/memory strobes, which also depend on mem_waitrequest.
- FETCH:
  - If pc_is_zero: next state HALT, no memory access.
  - Otherwise: mem_read=1, iord=0, alu_src_a=0, alu_src_b=1, alu_op=add.
  - ir_write and pc_write pulse only in the cycle where mem_waitrequest=0; that cycle goes to DECODE. Otherwise hold FETCH.
- DECODE: alu_src_a=0, alu_src_b=3, alu_op=add (branch target into ALUOut); always goes to EXEC.
- EXEC, by instruction class:
  - R-type ALU (opcode 0): alu_src_a=1, alu_src_b=0, alu_op=2; go WB.
  - jr (funct 0x08): pc_write=1, pc_source=3; go FETCH.
  - mult/multu/div/divu (funct 0x18-0x1B): go MULDIV, counter loads MULDIV_CYCLES-1.
  - lw/sw/sb/sh (0x23/0x2B/0x28/0x29): alu_src_a=1, alu_src_b=2, alu_op=add; go MEM.
  - beq/bne (0x04/0x05): alu_src_a=1, alu_src_b=0, alu_op=sub, pc_write_cond=1, pc_source=1; go FETCH.
  - j (0x02): pc_write=1, pc_source=2; go FETCH.
  - jal (0x03): pc_write=1, pc_source=2; go WB with reg_dst=2.
  - addiu/andi/ori/xori/slti/lui: alu_src_a=1, alu_src_b=2, alu_op per op; go WB.
  - Unrecognised opcode/funct: no strobes (NOP); go FETCH.
- MEM:
  - Load: mem_read=1, iord=1; leave to WB only when mem_waitrequest=0.
  - Store: mem_write=1, iord=1; leave to FETCH only when mem_waitrequest=0.
  - Strobes stay asserted and stable throughout the stall.
- WB: reg_write=1 for exactly one cycle; go FETCH.
  - reg_dst=1 for R-type, 0 for I-type, 2 for jal.
  - mem_to_reg=1 only for lw.
- MULDIV:
  - Counter decrements each cycle.
  - When counter==0: hi_lo_write=1 for that single cycle, next state FETCH.
  - MULDIV_CYCLES=1 therefore yields exactly one MULDIV cycle.
- HALT: absorbing; all strobes 0, active=0; exits only via reset.
- Reset asserted mid-instruction (including mid-stall or mid-MULDIV) aborts immediately; no partial write strobe is emitted after reset rises.

Optional Feature:
- Macro INSTR_COUNT_EN.
- Defined: adds output instr_count (32 bits), async-reset to 0. Increments by 1 on every transition into FETCH from EXEC, MEM, WB or MULDIV, i.e. once per retired instruction, NOPs included. Wraps 0xFFFFFFFF -> 0. Frozen in HALT.
- Undefined: port and counter are absent; all other behaviour is identical.

Test Plan:
- addu, mem_waitrequest=0 -> state sequence 0,1,2,4,0; reg_write=1 in WB only; reg_dst=1; alu_op=2 in EXEC.
- lw with mem_waitrequest held high 3 cycles in MEM -> MEM lasts 4 cycles with mem_read=1, iord=1 throughout; then WB with mem_to_reg=1, reg_write=1.
- mult, MULDIV_CYCLES=4 -> exactly 4 MULDIV cycles; hi_lo_write=1 only in the 4th; no reg_write.
- beq, then j -> EXEC shows pc_write_cond=1, pc_source=1; then pc_write=1, pc_source=2; both return to FETCH in 3 cycles.
- pc_is_zero=1 in FETCH -> HALT next cycle, active=0, mem_read=0. Remains so for 100 cycles; reset returns to FETCH with active=1.
- Reset pulsed during MULDIV count=2 -> state=FETCH immediately, hi_lo_write never asserted. With INSTR_COUNT_EN: instr_count=0, then 3 after three addu instructions.
